// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// eth_tx_arb_pkg : shared encodings and width-derived defaults for eth_tx_arb
// Rev 1.0
// ============================================================================
`ifndef ETH_OUTPUT_WIDTH
`define ETH_OUTPUT_WIDTH 8
`endif

package eth_tx_arb_pkg;

    localparam int ETH_W = `ETH_OUTPUT_WIDTH;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_GNT_ARP = 4'b0010,
        ST_GNT_UDP = 4'b0100,
        ST_IFG     = 4'b1000
    } state_t;

    typedef enum logic {
        OWN_ARP = 1'b0,
        OWN_UDP = 1'b1
    } owner_t;

    // MII moves a nibble per cycle, so the 96-bit gap needs twice the cycles.
    function automatic int ifg_for_width(input int w);
        return (w == 4) ? 24 : 12;
    endfunction

    localparam int IFG_DEFAULT = ifg_for_width(ETH_W);

endpackage
`default_nettype wire

// File: rtl/eth_tx_arb_if.sv
`default_nettype none
// ============================================================================
// eth_tx_arb_if : ARP/UDP source handshakes and PHY-side tx port of eth_tx_arb
// Rev 1.0
// ============================================================================
interface eth_tx_arb_if #(
  parameter int DATA_W = eth_tx_arb_pkg::ETH_W
);
  logic              arp_req;
  logic              arp_gnt;
  logic              arp_tx_en;
  logic [DATA_W-1:0] arp_tx_data;
  logic              arp_tx_done;
  logic              udp_req;
  logic              udp_gnt;
  logic              udp_tx_en;
  logic [DATA_W-1:0] udp_tx_data;
  logic              udp_tx_done;
  logic              eth_tx_en;
  logic [DATA_W-1:0] eth_tx_data;
  logic              err_collision;
  logic              err_timeout;

  modport master (
    output arp_req, arp_tx_en, arp_tx_data, arp_tx_done,
    output udp_req, udp_tx_en, udp_tx_data, udp_tx_done,
    input  arp_gnt, udp_gnt, eth_tx_en, eth_tx_data, err_collision, err_timeout
  );

  modport slave (
    input  arp_req, arp_tx_en, arp_tx_data, arp_tx_done,
    input  udp_req, udp_tx_en, udp_tx_data, udp_tx_done,
    output arp_gnt, udp_gnt, eth_tx_en, eth_tx_data, err_collision, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/eth_rr_arb2.sv
`default_nettype none
// ============================================================================
// eth_rr_arb2 : two-way round-robin picker; the source not granted last wins ties
// Rev 1.0
// ============================================================================
module eth_rr_arb2
  import eth_tx_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_arp,
  input  logic   req_udp,
  input  logic   take,
  output logic   valid,
  output owner_t winner
);

  owner_t r_last;

  always_comb begin
    valid  = req_arp | req_udp;
    winner = OWN_ARP;
    if (req_arp && req_udp) begin
      winner = (r_last == OWN_ARP) ? OWN_UDP : OWN_ARP;
    end else if (req_udp) begin
      winner = OWN_UDP;
    end
  end

  // Reset to UDP so ARP wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_UDP;
    end else if (take && valid) begin
      r_last <= winner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// ============================================================================
// eth_tx_arb : grants one MAC tx port to ARP or UDP, registered mux, IFG, watchdog
// Rev 1.0
// ============================================================================
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int          DATA_W  = ETH_W,
  parameter int          IFG_CYC = IFG_DEFAULT,
  parameter logic [15:0] MAX_CYC = 16'd3100
) (
  input  logic       clk,
  input  logic       rst_n,
  eth_tx_arb_if.slave bus
);

  localparam logic [7:0]  c_ifg_last = 8'(IFG_CYC - 1);
  localparam logic [15:0] c_wd_last  = MAX_CYC - 16'd1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_wd_cnt;
  logic [7:0]        r_ifg_cnt;
  logic              r_tx_en;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_err_coll;
  logic              w_pick_valid;
  owner_t            w_pick;
  logic              w_take;
  logic              w_in_gnt;
  logic              w_own_done;
  logic              w_wd_hit;
  logic              w_arp_gnt;
  logic              w_udp_gnt;
  logic              w_err_timeout;

  eth_rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_arp (bus.arp_req),
    .req_udp (bus.udp_req),
    .take    (w_take),
    .valid   (w_pick_valid),
    .winner  (w_pick)
  );

  assign w_take   = (r_state == ST_IDLE);
  assign w_in_gnt = (r_state == ST_GNT_ARP) || (r_state == ST_GNT_UDP);
  // Only the owner's done counts; a stray done from the other source is ignored.
  assign w_own_done = ((r_state == ST_GNT_ARP) && bus.arp_tx_done) ||
                      ((r_state == ST_GNT_UDP) && bus.udp_tx_done);
  assign w_wd_hit   = w_in_gnt && (r_wd_cnt == c_wd_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_arp_gnt     = (r_state == ST_GNT_ARP);
    w_udp_gnt     = (r_state == ST_GNT_UDP);
    w_err_timeout = w_wd_hit && !w_own_done;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = (w_pick == OWN_ARP) ? ST_GNT_ARP : ST_GNT_UDP;
        end
      end
      ST_GNT_ARP, ST_GNT_UDP: begin
        if (w_own_done || w_wd_hit) begin
          w_state_nxt = ST_IFG;
        end
      end
      ST_IFG: begin
        if (r_ifg_cnt == c_ifg_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wd_cnt  <= '0;
      r_ifg_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take && w_pick_valid) begin
        r_wd_cnt <= '0;
      end else if (w_in_gnt && (r_wd_cnt != 16'hFFFF)) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
      end
      if (w_in_gnt) begin
        r_ifg_cnt <= '0;
      end else if (r_state == ST_IFG) begin
        r_ifg_cnt <= r_ifg_cnt + 8'd1;
      end
    end
  end

  // Forwarding keys off the current state, so a forced release cuts tx_en
  // one cycle after leaving GNT no matter what the source still drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
      r_err_coll <= 1'b0;
    end else begin
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      if (r_state == ST_GNT_ARP) begin
        r_tx_en   <= bus.arp_tx_en;
        r_tx_data <= bus.arp_tx_data;
      end else if (r_state == ST_GNT_UDP) begin
        r_tx_en   <= bus.udp_tx_en;
        r_tx_data <= bus.udp_tx_data;
      end
      r_err_coll <= (bus.arp_tx_en && (r_state != ST_GNT_ARP)) ||
                    (bus.udp_tx_en && (r_state != ST_GNT_UDP));
    end
  end

  assign bus.arp_gnt       = w_arp_gnt;
  assign bus.udp_gnt       = w_udp_gnt;
  assign bus.eth_tx_en     = r_tx_en;
  assign bus.eth_tx_data   = r_tx_data;
  assign bus.err_collision = r_err_coll;
  assign bus.err_timeout   = w_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ============================================================================
// tb_eth_tx_arb : scoreboard bench for eth_tx_arb with a transaction-level model
// Rev 1.0
// ============================================================================
module tb_eth_tx_arb;
  import eth_tx_arb_pkg::*;

  localparam int IFG  = 12;
  localparam int MAXC = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_tx_arb_if #(.DATA_W(8)) bus ();

  eth_tx_arb #(
    .DATA_W  (8),
    .IFG_CYC (IFG),
    .MAX_CYC (16'(MAXC))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [7:0] data; int cyc; } beat_t;
  typedef struct { bit own; int rise; int fall; } gnt_t;

  beat_t exp_beat[$];
  gnt_t  exp_gnt[$];
  int    exp_to[$];
  int    exp_coll[$];

  int checks   = 0;
  int failures = 0;

  // Model state: earliest cycle a grant may appear, and who owned the link last.
  int free_cyc = 0;
  bit last_own = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  bit    prev_a = 1'b0;
  bit    prev_u = 1'b0;
  int    cur_fall = -1;
  beat_t mb;
  gnt_t  mg;
  int    mi;

  task automatic grant_rise(input bit own);
    check("gnt_expected", exp_gnt.size() != 0, 1);
    if (exp_gnt.size() != 0) begin
      mg = exp_gnt.pop_front();
      check("gnt_owner", own, mg.own);
      check("gnt_rise_cycle", cyc, mg.rise);
      cur_fall = mg.fall;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a   = 1'b0;
      prev_u   = 1'b0;
      cur_fall = -1;
    end else begin
      if (bus.arp_gnt && !prev_a) grant_rise(1'b0);
      if (bus.udp_gnt && !prev_u) grant_rise(1'b1);
      if (((!bus.arp_gnt && prev_a) || (!bus.udp_gnt && prev_u)) && cur_fall >= 0)
        check("gnt_fall_cycle", cyc, cur_fall);
      prev_a = bus.arp_gnt;
      prev_u = bus.udp_gnt;
      if (bus.eth_tx_en) begin
        check("beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          mb = exp_beat.pop_front();
          check("beat_data", bus.eth_tx_data, mb.data);
          check("beat_cycle", cyc, mb.cyc);
        end
      end else begin
        check("idle_data_zero", bus.eth_tx_data, 0);
      end
      if (bus.err_timeout) begin
        check("timeout_expected", exp_to.size() != 0, 1);
        if (exp_to.size() != 0) begin
          mi = exp_to.pop_front();
          check("timeout_cycle", cyc, mi);
        end
      end
      if (bus.err_collision) begin
        check("collision_expected", exp_coll.size() != 0, 1);
        if (exp_coll.size() != 0) begin
          mi = exp_coll.pop_front();
          check("collision_cycle", cyc, mi);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic bit pick(input bit a, input bit u, input bit last);
    return (a && u) ? !last : u;
  endfunction

  task automatic set_req(input bit own, input bit v);
    if (own) bus.udp_req = v;
    else     bus.arp_req = v;
  endtask

  task automatic set_tx(input bit own, input bit en, input logic [7:0] d, input bit done);
    if (own) begin
      bus.udp_tx_en = en; bus.udp_tx_data = d; bus.udp_tx_done = done;
    end else begin
      bus.arp_tx_en = en; bus.arp_tx_data = d; bus.arp_tx_done = done;
    end
  endtask

  // One complete frame from `own`, granted at g; optional intruding tx_en from
  // the other source for `coll` beats followed by a stray done pulse.
  task automatic run_frame(input bit own, input int g, input int gap, input int len, input int coll);
    int         start;
    int         d;
    logic [7:0] v;
    start = g + gap;
    d     = start + len - 1;
    exp_gnt.push_back('{own, g, d + 1});
    goto(g);
    set_req(own, 1'b0);
    goto(start);
    for (int i = 0; i < len; i++) begin
      v = 8'($urandom_range(0, 255));
      set_tx(own, 1'b1, v, i == len - 1);
      exp_beat.push_back('{v, cyc + 1});
      if (i < coll) begin
        set_tx(!own, 1'b1, 8'hAA, 1'b0);
        exp_coll.push_back(cyc + 1);
      end else if (coll > 0 && i == coll) begin
        set_tx(!own, 1'b0, 8'h00, 1'b1);
      end else begin
        set_tx(!own, 1'b0, 8'h00, 1'b0);
      end
      step();
    end
    set_tx(own, 1'b0, 8'h00, 1'b0);
    set_tx(!own, 1'b0, 8'h00, 1'b0);
    free_cyc = d + IFG + 2;
    last_own = own;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=%0d required=%0d cycles", cyc, 0);
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    int         r;
    int         g;
    int         k;
    int         dn;
    bit         own;
    logic [7:0] v;

    bus.arp_req = 0; bus.udp_req = 0;
    set_tx(1'b0, 1'b0, 8'h00, 1'b0);
    set_tx(1'b1, 1'b0, 8'h00, 1'b0);

    repeat (3) step();
    check("rst_eth_tx_en", bus.eth_tx_en, 0);
    check("rst_eth_tx_data", bus.eth_tx_data, 0);
    check("rst_arp_gnt", bus.arp_gnt, 0);
    check("rst_udp_gnt", bus.udp_gnt, 0);
    check("rst_err_collision", bus.err_collision, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    rst_n = 1'b1;

    // Single UDP frame.
    r = cyc + 9;
    goto(r);
    set_req(1'b1, 1'b1);
    own = pick(1'b0, 1'b1, last_own);
    run_frame(own, maxi(r + 1, free_cyc), $urandom_range(1, 4), $urandom_range(60, 100), 0);

    // Simultaneous requests, then a back-to-back pair raised during IFG.
    r = cyc + $urandom_range(0, 20);
    goto(r);
    set_req(1'b0, 1'b1); set_req(1'b1, 1'b1);
    own = pick(1'b1, 1'b1, last_own);
    run_frame(own, maxi(r + 1, free_cyc), $urandom_range(0, 3), $urandom_range(16, 40), 0);
    own = pick(own == 1'b1, own == 1'b0, last_own);
    run_frame(own, free_cyc, $urandom_range(0, 3), $urandom_range(16, 40), 0);
    r = cyc;
    set_req(1'b0, 1'b1); set_req(1'b1, 1'b1);
    own = pick(1'b1, 1'b1, last_own);
    run_frame(own, maxi(r + 1, free_cyc), $urandom_range(0, 3), $urandom_range(16, 40), 0);
    own = pick(own == 1'b1, own == 1'b0, last_own);
    run_frame(own, free_cyc, $urandom_range(0, 3), $urandom_range(16, 40), 0);

    // UDP request three cycles after done, with ARP colliding during the grant.
    dn = free_cyc - IFG - 2;
    goto(dn + 3);
    set_req(1'b1, 1'b1);
    own = pick(1'b0, 1'b1, last_own);
    run_frame(own, maxi(dn + 4, free_cyc), $urandom_range(0, 2), $urandom_range(16, 40), 5);

    // Watchdog: ARP never signals done and keeps driving past the forced release.
    r = cyc + 2;
    goto(r);
    set_req(1'b0, 1'b1);
    g = maxi(r + 1, free_cyc);
    exp_gnt.push_back('{1'b0, g, g + MAXC});
    exp_to.push_back(g + MAXC - 1);
    goto(g);
    set_req(1'b0, 1'b0);
    step();
    while (cyc <= g + MAXC - 1 + 3) begin
      v = 8'($urandom_range(0, 255));
      set_tx(1'b0, 1'b1, v, 1'b0);
      if (cyc <= g + MAXC - 1) exp_beat.push_back('{v, cyc + 1});
      else                     exp_coll.push_back(cyc + 1);
      if (cyc == g + 10) set_req(1'b1, 1'b1);
      step();
    end
    set_tx(1'b0, 1'b0, 8'h00, 1'b0);
    free_cyc = g + MAXC - 1 + IFG + 2;
    last_own = 1'b0;
    own = pick(1'b0, 1'b1, last_own);
    run_frame(own, free_cyc, $urandom_range(0, 3), $urandom_range(16, 40), 0);

    // Reset in the middle of a UDP payload.
    r = cyc + 1;
    goto(r);
    set_req(1'b1, 1'b1);
    g = maxi(r + 1, free_cyc);
    exp_gnt.push_back('{1'b1, g, -1});
    goto(g);
    set_req(1'b1, 1'b0);
    step();
    k = $urandom_range(3, 10);
    for (int i = 0; i < k; i++) begin
      v = 8'($urandom_range(0, 255));
      set_tx(1'b1, 1'b1, v, 1'b0);
      if (i < k - 1) begin
        exp_beat.push_back('{v, cyc + 1});
        step();
      end
    end
    #6;
    check("pre_reset_eth_tx_en", bus.eth_tx_en, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_eth_tx_en", bus.eth_tx_en, 0);
    check("async_rst_udp_gnt", bus.udp_gnt, 0);
    check("async_rst_arp_gnt", bus.arp_gnt, 0);
    check("async_rst_err_collision", bus.err_collision, 0);
    check("async_rst_err_timeout", bus.err_timeout, 0);
    set_tx(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    step();
    set_req(1'b0, 1'b1); set_req(1'b1, 1'b1);
    rst_n    = 1'b1;
    free_cyc = 0;
    last_own = 1'b1;
    own = pick(1'b1, 1'b1, last_own);
    run_frame(own, cyc + 1, $urandom_range(0, 3), $urandom_range(16, 40), 0);
    own = pick(own == 1'b1, own == 1'b0, last_own);
    run_frame(own, free_cyc, $urandom_range(0, 3), $urandom_range(16, 40), 0);

    repeat (30) step();
    check("leftover_grants", exp_gnt.size(), 0);
    check("leftover_beats", exp_beat.size(), 0);
    check("leftover_timeouts", exp_to.size(), 0);
    check("leftover_collisions", exp_coll.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Arbitrates one physical MAC transmit interface between two frame sources: the ARP responder and the UDP sender (an ip_send instance).
- Grants the interface to one source at a time, round-robin, and muxes that source's tx_en/data onto the PHY-side port with one register stage.
- Enforces the Ethernet inter-frame gap after every frame.
- Runs a watchdog so a hung source cannot hold the link.

Parameters:
- DATA_W, 8, nibble/byte width of the tx data path; must equal `ETH_OUTPUT_WIDTH (4 for MII, 8 for GMII).
- IFG_CYC, 12, idle cycles after each frame; use 24 when DATA_W=4.
- MAX_CYC, 16'd3100, maximum grant duration in cycles before a forced release.

Ports:
- clk  in  1  system/tx clock
- rst_n  in  1  asynchronous active-low reset
- arp_req  in  1  ARP source requests the link; level, held until arp_gnt
- arp_gnt  out  1  ARP source owns the link
- arp_tx_en  in  1  ARP frame valid
- arp_tx_data  in  DATA_W  ARP frame data
- arp_tx_done  in  1  one-cycle pulse, ARP frame complete
- udp_req  in  1  UDP source requests the link
- udp_gnt  out  1  UDP source owns the link; the source raises tx_start_en on its rising edge
- udp_tx_en  in  1  UDP frame valid
- udp_tx_data  in  DATA_W  UDP frame data
- udp_tx_done  in  1  one-cycle pulse, UDP frame complete
- eth_tx_en  out  1  muxed tx enable to PHY interface
- eth_tx_data  out  DATA_W  muxed tx data
- err_collision  out  1  one-cycle pulse: a non-granted source asserted tx_en
- err_timeout  out  1  one-cycle pulse: watchdog forced a release

Behaviour:
- Reset values: all outputs 0; state IDLE; last_owner = UDP, so ARP wins the first tie; all counters 0.
- States are one-hot: IDLE, GNT_ARP, GNT_UDP, IFG.
- IDLE:
  - Request present -> go to the GNT_x state for that source.
  - Both requests present -> grant the source that is not last_owner.
  - No request -> remain in IDLE.
  - Arbitration takes one cycle: a request sampled in cycle N gives x_gnt=1 in cycle N+1.
- GNT_x:
  - x_gnt is held at 1 for the whole state.
  - last_owner is updated on entry.
  - wd_cnt increments every cycle from 0.
  - Exit to IFG on the cycle after x_tx_done=1, so gnt falls one cycle after the done pulse.
  - Exit to IFG if wd_cnt reaches MAX_CYC-1 before done; err_timeout pulses for one cycle.
  - x_req may drop while granted; it has no effect, and only done or the watchdog releases the grant.
- IFG:
  - Counts IFG_CYC cycles, then goes to IDLE.
  - Requests arriving during IFG are held by their sources and arbitrated in IDLE.
  - Minimum gap, done to next gnt: IFG_CYC+2 cycles.
- Output mux:
  - Registered, one-cycle latency.
  - GNT_ARP: eth_tx_en <= arp_tx_en, eth_tx_data <= arp_tx_data.
  - GNT_UDP: same from the UDP inputs.
  - Any other state: eth_tx_en <= 0 and eth_tx_data <= 0. No tri-state on the output.
- Forced-release cut: after a timeout, eth_tx_en drops one cycle after the state leaves GNT_x, even if the source still drives tx_en.
- Collision detect:
  - err_collision pulses (registered) when a non-owner asserts tx_en, in any state including IDLE/IFG.
  - The non-owner data is never forwarded.
- Simultaneous events:
  - A request that arrives in the same cycle as x_tx_done is not granted until IFG has completed.
  - A tx_done from the non-owner is ignored.
- Reset mid-frame: eth_tx_en and both gnts go low immediately (asynchronous), and the FSM returns to IDLE.
- Counter widths:
  - wd_cnt is 16 bit, saturating, cleared on GNT entry.
  - ifg_cnt is 8 bit, cleared on IFG entry.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE/ST_GNT_ARP/ST_GNT_UDP/ST_IFG
  - owner IDs (OWN_ARP=0, OWN_UDP=1)
  - default IFG per width, derived from `ETH_OUTPUT_WIDTH in eth_net.v
- Sub-module: one natural sub-module, eth_rr_arb2 (2-way round-robin picker with last-owner register). Mux, watchdog and IFG stay in the top.

Test Plan:
- Single UDP: udp_req=1 at cycle 10 -> udp_gnt=1 at 11.
  - 100-cycle tx_en burst at 20..119 appears on eth_tx_en at 21..120 with identical data.
  - udp_tx_done at 119 -> udp_gnt=0 at 120.
  - Next grant no earlier than 133 (IFG_CYC=12).
- Tie: arp_req and udp_req rise together after reset -> ARP granted first, then UDP after done+IFG.
  - A third back-to-back pair of requests goes to ARP again (round-robin).
- Request during IFG: udp_req at done+3 -> no grant until IFG expires; udp_gnt at done+IFG_CYC+2.
- Watchdog: grant ARP and never pulse done, MAX_CYC=200 -> err_timeout pulses at grant+199 and arp_gnt falls.
  - eth_tx_en is 0 one cycle later.
  - UDP is then serviced after IFG.
- Collision: during GNT_UDP drive arp_tx_en=1 for 5 cycles with data 8'hAA -> err_collision pulses 5 times.
  - eth_tx_data never shows 8'hAA.
- Reset mid-frame: assert rst_n=0 during UDP payload -> eth_tx_en, udp_gnt and errors are 0 asynchronously.
  - After release, ARP wins the first tie.
